// File: rtl/data_ram_ctrl.sv
// Word-addressed data RAM behind a req/ready handshake with a fixed, programmable access time.
// Each access takes IDLE -> WAIT (WAIT_STATES cycles) -> DONE, or IDLE -> DONE when WAIT_STATES is 0.
module data_ram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              RW,
  input  logic [31:0]       address_in,
  input  logic [DATA_W-1:0] RAM_in,
  output logic [DATA_W-1:0] RAM_out,
  output logic              ready,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rw_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              exec;
  logic              exec_rw;
  logic [31:0]       exec_addr;
  logic [DATA_W-1:0] exec_data;
  logic [ADDR_W-1:0] exec_idx;
  logic              exec_err;

  // The access runs on the edge entering DONE; with no wait states that is the
  // accepting edge itself, so the live inputs stand in for the not-yet-latched copies.
  always_comb begin
    exec      = 1'b0;
    exec_rw   = rw_q;
    exec_addr = addr_q;
    exec_data = data_q;
    if (state == IDLE && req && WAIT_STATES == 0) begin
      exec      = 1'b1;
      exec_rw   = RW;
      exec_addr = address_in;
      exec_data = RAM_in;
    end else if (state == WAIT && cnt == 4'd0) begin
      exec = 1'b1;
    end
  end

  assign exec_idx = exec_addr[ADDR_W-1:0];
  assign exec_err = |exec_addr[31:ADDR_W];

  // Array is never cleared; a reset on the committing edge cancels the write.
  always_ff @(posedge clk) begin
    if (exec && !Reset && !exec_rw && !exec_err) begin
      mem[exec_idx] <= exec_data;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      RAM_out  <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready    <= 1'b0;
          addr_err <= 1'b0;
          busy     <= 1'b0;
          if (req) begin
            addr_q <= address_in;
            data_q <= RAM_in;
            rw_q   <= RW;
            busy   <= 1'b1;
            cnt    <= CNT_INIT;
            state  <= (WAIT_STATES > 0) ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          ready    <= 1'b0;
          addr_err <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (exec) begin
        ready    <= 1'b1;
        addr_err <= exec_err;
        if (exec_rw) begin
          RAM_out <= exec_err ? '0 : mem[exec_idx];
        end
      end
    end
  end

endmodule
